// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and elaboration helpers for the pipelined adder.
//   ADDER_DEFAULT_WIDTH  - default operand width
//   ADDER_DEFAULT_STAGES - default pipeline depth
//   seg_width()          - bits per pipeline segment
//   stages_legal()       - true when WIDTH splits evenly into STAGES segments
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH  = 16;
  localparam int ADDER_DEFAULT_STAGES = 1;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit stages_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_if.sv
// adder_if: operand/result bundle for the adder.
//   a, b  - unsigned operands (WIDTH bits)
//   valid - operands qualified this cycle
//   sum   - full-precision result with carry in the MSB (WIDTH+1 bits)
// Modports: master drives operands and reads sum; slave is the adder side.
interface adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             valid;
  logic [WIDTH:0]   sum;

  modport master (output a, output b, output valid, input sum);
  modport slave  (input a, input b, input valid, output sum);

endinterface

// File: rtl/adder_segment.sv
// adder_segment: one registered SEG-bit slice of the pipelined adder.
//   clk, rst  - clock, async active-low reset
//   vin       - token valid entering this slice
//   a, b, cin - segment operands and carry from the previous slice
//   s, cout   - registered segment sum and carry-out
//   vout      - registered valid token
// Data registers only load on a valid token, so idle cycles neither disturb
// in-flight results nor let unqualified operand values in.
module adder_segment #(
  parameter int SEG = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vin,
  input  logic           cin,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           vout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s    <= '0;
      cout <= 1'b0;
      vout <= 1'b0;
    end else begin
      vout <= vin;
      if (vin) begin
        {cout, s} <= {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
      end
    end
  end

endmodule

// File: rtl/adder_modport.sv
// adder_modport: registered, optionally pipelined unsigned adder.
//   clk - rising-edge clock
//   rst - async active-low reset
//   bus - adder_if slave modport (a, b, valid in; sum out)
// Operands are cut into STAGES segments; stage k adds segment k with the
// carry registered by stage k-1. Each stage carries forward the unconsumed
// upper operand bits and the finished lower result bits, so operand alignment
// and result de-skew both fall out of the same per-stage registers. A final
// output register loads only when a valid token leaves the last stage, giving
// a latency of STAGES edges from capture to sum.
module adder_modport
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_DEFAULT_WIDTH,
  parameter int STAGES = ADDER_DEFAULT_STAGES
) (
  input logic    clk,
  input logic    rst,
  adder_if.slave bus
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!stages_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("adder_modport: STAGES must be 1..WIDTH and divide WIDTH evenly");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added from this stage upward.
    localparam int OPW = WIDTH - k * SEG;

    logic                 vin;
    logic                 cin;
    logic [OPW-1:0]       a_op;
    logic [OPW-1:0]       b_op;
    logic [SEG-1:0]       seg_s;
    logic                 cout;
    logic                 vout;
    logic [(k+1)*SEG-1:0] res;

    if (k == 0) begin : g_head
      assign vin  = bus.valid;
      assign cin  = 1'b0;
      assign a_op = bus.a;
      assign b_op = bus.b;
      assign res  = seg_s;
    end else begin : g_body
      logic [k*SEG-1:0] lo;

      assign vin = g_stage[k-1].vout;
      assign cin = g_stage[k-1].cout;

      // Upper operand bits ride alongside the token, one stage behind.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_op <= '0;
          b_op <= '0;
        end else if (g_stage[k-1].vin) begin
          a_op <= g_stage[k-1].a_op[OPW+SEG-1:SEG];
          b_op <= g_stage[k-1].b_op[OPW+SEG-1:SEG];
        end
      end

      // Finished lower result bits wait here for the upper segments.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lo <= '0;
        end else if (vin) begin
          lo <= g_stage[k-1].res;
        end
      end

      assign res = {seg_s, lo};
    end

    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .clk  (clk),
      .rst  (rst),
      .vin  (vin),
      .cin  (cin),
      .a    (a_op[SEG-1:0]),
      .b    (b_op[SEG-1:0]),
      .s    (seg_s),
      .cout (cout),
      .vout (vout)
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.sum <= '0;
    end else if (g_stage[STAGES-1].vout) begin
      bus.sum <= {g_stage[STAGES-1].cout, g_stage[STAGES-1].res};
    end
  end

endmodule

// File: tb/tb_adder_modport.sv
// Bench for adder_modport: four instances (STAGES 1, 2, 4, 8; WIDTH 16) share
// one operand stream. Directed vectors carry hand-computed sums; a latency
// model of "sum = a+b sampled STAGES edges ago, else hold" is compared on
// every step, including a long random run.
module tb_adder_modport;
  import adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [16:0] sums [4];

  int n_chk;
  int n_err;

  adder_if #(.WIDTH(16)) bus_s1 ();
  adder_if #(.WIDTH(16)) bus_s2 ();
  adder_if #(.WIDTH(16)) bus_s4 ();
  adder_if #(.WIDTH(16)) bus_s8 ();

  assign bus_s1.a = a;  assign bus_s1.b = b;  assign bus_s1.valid = valid;
  assign bus_s2.a = a;  assign bus_s2.b = b;  assign bus_s2.valid = valid;
  assign bus_s4.a = a;  assign bus_s4.b = b;  assign bus_s4.valid = valid;
  assign bus_s8.a = a;  assign bus_s8.b = b;  assign bus_s8.valid = valid;

  assign sums[0] = bus_s1.sum;
  assign sums[1] = bus_s2.sum;
  assign sums[2] = bus_s4.sum;
  assign sums[3] = bus_s8.sum;

  adder_modport #(.WIDTH(16), .STAGES(1)) u_s1 (.clk(clk), .rst(rst), .bus(bus_s1));
  adder_modport #(.WIDTH(16), .STAGES(2)) u_s2 (.clk(clk), .rst(rst), .bus(bus_s2));
  adder_modport #(.WIDTH(16), .STAGES(4)) u_s4 (.clk(clk), .rst(rst), .bus(bus_s4));
  adder_modport #(.WIDTH(16), .STAGES(8)) u_s8 (.clk(clk), .rst(rst), .bus(bus_s8));

  always #5 clk = ~clk;

  // Latency model state: input history ring and expected sum per instance.
  logic [15:0] ha [16];
  logic [15:0] hb [16];
  bit          hv [16];
  logic [16:0] mexp [4];
  int          ecnt;

  logic [15:0] va [7];
  logic [15:0] vb [7];
  logic [16:0] ve [7];

  function automatic int stg(input int s);
    return 1 << s;
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) hv[i] = 1'b0;
    for (int s = 0; s < 4; s++) mexp[s] = '0;
  endtask

  // One clock: record sampled inputs, advance the model, compare #1 later.
  task automatic step();
    int idx;
    @(posedge clk);
    ha[ecnt % 16] = a;
    hb[ecnt % 16] = b;
    hv[ecnt % 16] = (rst === 1'b1) && (valid === 1'b1);
    for (int s = 0; s < 4; s++) begin
      if (rst !== 1'b1) begin
        mexp[s] = '0;
      end else if (ecnt >= stg(s)) begin
        idx = (ecnt - stg(s)) % 16;
        if (hv[idx]) mexp[s] = {1'b0, ha[idx]} + {1'b0, hb[idx]};
      end
    end
    ecnt++;
    #1;
    for (int s = 0; s < 4; s++) chk($sformatf("model_s%0d", stg(s)), sums[s], mexp[s]);
  endtask

  // Assert reset between edges and confirm outputs clear before the next edge.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b0;
    model_clear();
    #1;
    for (int s = 0; s < 4; s++) chk($sformatf("%s_s%0d", tag, stg(s)), sums[s], 17'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    ecnt  = 0;
    rst   = 1'b0;
    valid = 1'b0;
    a     = '0;
    b     = '0;
    model_clear();

    va[0] = 16'hFFFF; vb[0] = 16'hFFFF; ve[0] = 17'h1FFFE;
    va[1] = 16'hFFFF; vb[1] = 16'h0001; ve[1] = 17'h10000;
    va[2] = 16'h0000; vb[2] = 16'h0000; ve[2] = 17'h00000;
    va[3] = 16'h0001; vb[3] = 16'h0001; ve[3] = 17'h00002;
    va[4] = 16'h00FF; vb[4] = 16'h0001; ve[4] = 17'h00100;
    va[5] = 16'h0FFF; vb[5] = 16'h0001; ve[5] = 17'h01000;
    va[6] = 16'hFFFF; vb[6] = 16'h0001; ve[6] = 17'h10000;

    // Reset held with live operands.
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      valid = 1'b1;
      step();
      for (int s = 0; s < 4; s++) chk($sformatf("rst_hold_s%0d", stg(s)), sums[s], 17'd0);
    end

    // Basic add and hold.
    rst = 1'b1;
    a = 16'd3; b = 16'd5; valid = 1'b1;
    step();
    chk("basic_early_s1", sums[0], 17'd0);
    a = 16'd100; b = 16'd200; valid = 1'b0;
    step();
    chk("basic_s1", sums[0], 17'd8);
    chk("basic_early_s2", sums[1], 17'd0);
    step();
    chk("basic_s2", sums[1], 17'd8);
    chk("basic_hold_s1", sums[0], 17'd8);
    step();
    chk("basic_early_s4", sums[2], 17'd0);
    step();
    chk("basic_s4", sums[2], 17'd8);
    for (int i = 0; i < 4; i++) step();
    chk("basic_s8", sums[3], 17'd8);
    chk("basic_hold2_s1", sums[0], 17'd8);

    async_reset("async_rst");
    step();
    rst = 1'b1;

    // Carry boundaries and back-to-back streaming across segment edges.
    for (int k = 1; k <= 16; k++) begin
      if (k <= 7) begin
        a = va[k-1]; b = vb[k-1]; valid = 1'b1;
      end else begin
        a = 16'hDEAD; b = 16'hBEEF; valid = 1'b0;
      end
      step();
      for (int s = 0; s < 4; s++) begin
        int j;
        j = k - 1 - stg(s);
        if (j >= 0)
          chk($sformatf("tbl_s%0d_v%0d", stg(s), j), sums[s], ve[(j < 7) ? j : 6]);
      end
    end

    // Reset while two results are in flight.
    a = 16'd3; b = 16'd4; valid = 1'b1;
    step();
    a = 16'd5; b = 16'd6;
    step();
    valid = 1'b0;
    step();
    async_reset("mid_rst");
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_post_s4", sums[2], 17'd0);
      chk("mid_post_s8", sums[3], 17'd0);
    end
    a = 16'd7; b = 16'd8; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_new_s4", sums[2], 17'd15);
    chk("mid_new_s1", sums[0], 17'd15);

    // Random stream against the latency model.
    for (int i = 0; i < 10000; i++) begin
      valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       begin a = 16'hFFFF; b = 16'($urandom); end
        1:       begin a = 16'($urandom); b = 16'hFFFF; end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      step();
    end
    valid = 1'b0;
    for (int i = 0; i < 10; i++) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
